mac_seq_ctrl: RTL

//  Sequencer for one MAC datapath: computes one length-N dot product per job and returns it over a

---
 rtl/mac_seq_ctrl_pkg.sv | 16 +
 rtl/mac_seq_ctrl_if.sv | 32 +++
 rtl/mac_seq_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding and the MAC pipeline depth.
// The attached MAC is built against the same MAC_LAT constant.
package mac_seq_ctrl_pkg;

  localparam int MAC_LAT = 3;
  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FEED   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_RESULT = 3'd3,
    ST_CLEAR  = 3'd4
  } state_e;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Scheduler-facing bundle of the MAC sequencer: job request, operand pair stream, result stream.
// Handshakes: a beat moves on a rising edge where valid && ready; valid never waits on ready,
// and a producer holds its data stable while valid is high and ready is low.
interface mac_seq_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;

  logic             pair_valid;
  logic             pair_ready;
  logic [WIDTH-1:0] pair_in;
  logic [WIDTH-1:0] pair_w;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport master (
    output start, len, pair_valid, pair_in, pair_w, res_ready,
    input  busy, pair_ready, res_valid, res_data
  );

  modport slave (
    input  start, len, pair_valid, pair_in, pair_w, res_ready,
    output busy, pair_ready, res_valid, res_data
  );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one MAC: streams a length-N job of operand pairs into the MAC, waits out the
// MAC pipeline, returns the captured dot product, then clears the MAC with a one-cycle reset.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  mac_seq_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] mac_in,
  output logic [WIDTH-1:0] mac_w,
  output logic             mac_rstb,
  input  logic [WIDTH-1:0] mac_out,
  output state_e           state_dbg
);

  state_e             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beats;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [WIDTH-1:0]   res_data_q;
  logic               clr_n_q;
  logic               accept;

  assign accept = (state == ST_FEED) && bus.pair_valid;

  // Idle cycles feed zero products, which leave the MAC accumulator untouched.
  assign mac_in = accept ? bus.pair_in : '0;
  assign mac_w  = accept ? bus.pair_w  : '0;

  // clr_n_q is a flop, so this gate cannot glitch the MAC reset.
  assign mac_rstb = rstb & clr_n_q;

  assign bus.busy       = (state != ST_IDLE);
  assign bus.pair_ready = (state == ST_FEED);
  assign bus.res_valid  = (state == ST_RESULT);
  assign bus.res_data   = res_data_q;
  assign state_dbg      = state;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      beats      <= '0;
      drain_cnt  <= '0;
      res_data_q <= '0;
      clr_n_q    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            len_q     <= bus.len;
            beats     <= '0;
            drain_cnt <= '0;
            // A zero-length job still drains and reports, yielding the cleared MAC value.
            state     <= (bus.len != '0) ? ST_FEED : ST_DRAIN;
          end
        end
        ST_FEED: begin
          if (bus.pair_valid) begin
            beats <= beats + LEN_W'(1);
            if (beats == len_q - LEN_W'(1)) begin
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_W'(MAC_LAT - 1)) begin
            res_data_q <= mac_out;
            state      <= ST_RESULT;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            clr_n_q <= 1'b0;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          clr_n_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          clr_n_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
